// File: rtl/memory_unit_pkg.sv
// Shared definitions for the unified 256-byte memory of the multi-cycle core:
// bus geometry, memory map boundaries, access-size and extension encodings,
// and a helper that turns an access size into a byte count.
package memory_unit_pkg;

  localparam int BUS_WIDTH = 32;
  localparam int MEM_BYTES = 256;
  localparam int INSTR_END = 64;
  localparam int MMIO_BASE = 128;
  localparam int ADDR_BITS = $clog2(MEM_BYTES);
  localparam int LANES     = BUS_WIDTH / 8;

  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10,
    WORD_ALT  = 2'b11
  } mem_size_e;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_sel_e;

  // Number of bytes touched by an access; the unused encoding behaves as a word.
  function automatic logic [2:0] access_bytes(input logic [1:0] sz);
    case (sz)
      BYTE:      access_bytes = 3'd1;
      HALF_WORD: access_bytes = 3'd2;
      default:   access_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_unit_if.sv
// Load/store bus between the core and memory_unit.
//   wr_en, address, in_val, mem_size, mem_sz_ex_sel : core -> memory
//   out_val (combinational read data), mem_map_io   : memory -> core
interface memory_unit_if;
  import memory_unit_pkg::*;

  logic                 wr_en;
  logic [BUS_WIDTH-1:0] address;
  logic [BUS_WIDTH-1:0] in_val;
  logic [1:0]           mem_size;
  logic                 mem_sz_ex_sel;
  logic [BUS_WIDTH-1:0] out_val;
  logic [BUS_WIDTH-1:0] mem_map_io;

  modport master (
    output wr_en, address, in_val, mem_size, mem_sz_ex_sel,
    input  out_val, mem_map_io
  );

  modport slave (
    input  wr_en, address, in_val, mem_size, mem_sz_ex_sel,
    output out_val, mem_map_io
  );
endinterface

// File: rtl/memory_unit_load_extend.sv
// load_extend: sizes a raw little-endian 4-byte gather to byte/half/word and
// sign- or zero-extends it.
//   raw           in  32  bytes address..address+3, byte 0 in bits [7:0]
//   mem_size      in  2   access size encoding
//   mem_sz_ex_sel in  1   0 = sign-extend, 1 = zero-extend
//   out_val       out 32  extended read data
module load_extend
  import memory_unit_pkg::*;
(
  input  logic [BUS_WIDTH-1:0] raw,
  input  logic [1:0]           mem_size,
  input  logic                 mem_sz_ex_sel,
  output logic [BUS_WIDTH-1:0] out_val
);

  logic zext;

  always_comb begin
    zext    = (mem_sz_ex_sel == EXT_ZERO);
    out_val = raw;
    case (mem_size)
      BYTE:      out_val = zext ? {24'h0, raw[7:0]}
                                : {{24{raw[7]}}, raw[7:0]};
      HALF_WORD: out_val = zext ? {16'h0, raw[15:0]}
                                : {{16{raw[15]}}, raw[15:0]};
      default:   out_val = raw;
    endcase
  end

endmodule

// File: rtl/memory_unit.sv
// memory_unit: unified byte-addressable memory for the multi-cycle core.
//   [0, INSTR_END)          instruction region, never writable after load
//   [INSTR_END, MEM_BYTES)  data region, cleared by reset
//   [MMIO_BASE, +3]         MMIO register, mirrored on mem_map_io
// Ports:
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (wins over a same-cycle write)
//   bus  slave side of memory_unit_if
// Build option: define MEM_PRELOAD_EN to load the instruction region from
// the PROGRAM_IMAGE constant; otherwise it reads as all zeros.
module memory_unit
  import memory_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  bus
);

  logic [7:0]           data_mem  [INSTR_END:MEM_BYTES-1];
  logic [7:0]           instr_rom [INSTR_END];
  logic [7:0]           mem_view  [MEM_BYTES];

  logic [BUS_WIDTH:0]   lane_sum  [LANES];
  logic [ADDR_BITS-1:0] lane_idx  [LANES];
  logic [LANES-1:0]     lane_valid;
  logic [LANES-1:0]     lane_wr;
  logic [2:0]           n_bytes;
  logic [BUS_WIDTH-1:0] rd_raw;

`ifdef MEM_PRELOAD_EN
  localparam logic [7:0] PROGRAM_IMAGE [INSTR_END] = '{default: 8'h00};

  for (genvar b = 0; b < INSTR_END; b++) begin : g_rom_load
    assign instr_rom[b] = PROGRAM_IMAGE[b];
  end
`else
  for (genvar b = 0; b < INSTR_END; b++) begin : g_rom_zero
    assign instr_rom[b] = 8'h00;
  end
`endif

  for (genvar b = 0; b < MEM_BYTES; b++) begin : g_view
    if (b < INSTR_END) begin : g_instr
      assign mem_view[b] = instr_rom[b];
    end else begin : g_data
      assign mem_view[b] = data_mem[b];
    end
  end

  // Each lane is resolved independently: the sum is one bit wider than the
  // address so high addresses cannot wrap back into the array.
  always_comb begin
    n_bytes    = access_bytes(bus.mem_size);
    lane_valid = '0;
    lane_wr    = '0;
    rd_raw     = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum[i]   = {1'b0, bus.address} + (BUS_WIDTH+1)'(i);
      lane_idx[i]   = lane_sum[i][ADDR_BITS-1:0];
      lane_valid[i] = lane_sum[i] < (BUS_WIDTH+1)'(MEM_BYTES);
      lane_wr[i]    = lane_valid[i]
                      && (lane_sum[i] >= (BUS_WIDTH+1)'(INSTR_END))
                      && (3'(i) < n_bytes);
      if (lane_valid[i]) begin
        rd_raw[8*i +: 8] = mem_view[lane_idx[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = INSTR_END; b < MEM_BYTES; b++) begin
        data_mem[b] <= 8'h00;
      end
    end else if (bus.wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_wr[i]) begin
          data_mem[lane_idx[i]] <= bus.in_val[8*i +: 8];
        end
      end
    end
  end

  load_extend u_load_extend (
    .raw           (rd_raw),
    .mem_size      (bus.mem_size),
    .mem_sz_ex_sel (bus.mem_sz_ex_sel),
    .out_val       (bus.out_val)
  );

  assign bus.mem_map_io = {mem_view[MMIO_BASE+3], mem_view[MMIO_BASE+2],
                           mem_view[MMIO_BASE+1], mem_view[MMIO_BASE]};

endmodule

// File: tb/tb_memory_unit.sv
module tb_memory_unit;
  import memory_unit_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        ext;
    logic [31:0] exp_out;
    logic [31:0] exp_mmio;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  memory_unit_if bus ();

  memory_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic [1:0] size, input logic ext,
                     input logic [31:0] exp_out, input logic [31:0] exp_mmio);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.size = size; v.ext = ext;
    v.exp_out = exp_out; v.exp_mmio = exp_mmio;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input logic ext);
    bus.wr_en         = wr;
    bus.address       = addr;
    bus.in_val        = data;
    bus.mem_size      = size;
    bus.mem_sz_ex_sel = ext;
  endtask

  task automatic read_chk(input string name, input logic [31:0] addr, input logic [1:0] size,
                          input logic ext, input logic [31:0] exp);
    drive(1'b0, addr, 32'h0, size, ext);
    #1;
    check(name, bus.out_val, exp);
  endtask

  initial begin
    //    wr    addr          data          size   ext   exp_out       exp_mmio
    add(1'b0, 32'd64,       32'h0,        2'b10, 1'b0, 32'h00000000, 32'h00000000);
    add(1'b1, 32'd65,       32'h0000FFFF, 2'b00, 1'b0, 32'h0,        32'h00000000);
    add(1'b0, 32'd64,       32'h0,        2'b10, 1'b0, 32'h0000FF00, 32'h00000000);
    add(1'b0, 32'd65,       32'h0,        2'b00, 1'b0, 32'hFFFFFFFF, 32'h00000000);
    add(1'b0, 32'd65,       32'h0,        2'b00, 1'b1, 32'h000000FF, 32'h00000000);
    add(1'b1, 32'd4,        32'h0000FFFF, 2'b10, 1'b0, 32'h0,        32'h00000000);
    add(1'b0, 32'd4,        32'h0,        2'b10, 1'b0, 32'h00000000, 32'h00000000);
    add(1'b1, 32'd63,       32'h0000ABCD, 2'b01, 1'b0, 32'h0,        32'h00000000);
    add(1'b0, 32'd64,       32'h0,        2'b10, 1'b0, 32'h0000FFAB, 32'h00000000);
    add(1'b0, 32'd60,       32'h0,        2'b10, 1'b0, 32'h00000000, 32'h00000000);
    add(1'b1, 32'd128,      32'h0000FFFF, 2'b00, 1'b0, 32'h0,        32'h000000FF);
    add(1'b0, 32'd128,      32'h0,        2'b10, 1'b0, 32'h000000FF, 32'h000000FF);
    add(1'b1, 32'd128,      32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF);
    add(1'b0, 32'd129,      32'h0,        2'b01, 1'b1, 32'h0000ADBE, 32'hDEADBEEF);
    add(1'b0, 32'd129,      32'h0,        2'b01, 1'b0, 32'hFFFFADBE, 32'hDEADBEEF);
    add(1'b0, 32'd131,      32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 32'hDEADBEEF);
    add(1'b0, 32'd128,      32'h0,        2'b11, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF);
    add(1'b1, 32'd100,      32'h00008001, 2'b01, 1'b0, 32'h0,        32'hDEADBEEF);
    add(1'b0, 32'd100,      32'h0,        2'b01, 1'b0, 32'hFFFF8001, 32'hDEADBEEF);
    add(1'b0, 32'd100,      32'h0,        2'b01, 1'b1, 32'h00008001, 32'hDEADBEEF);
    add(1'b1, 32'd254,      32'h11223344, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF);
    add(1'b0, 32'd256,      32'h0,        2'b10, 1'b0, 32'h00000000, 32'hDEADBEEF);
    add(1'b0, 32'd254,      32'h0,        2'b10, 1'b0, 32'h00003344, 32'hDEADBEEF);
    add(1'b0, 32'd255,      32'h0,        2'b01, 1'b1, 32'h00000033, 32'hDEADBEEF);
    add(1'b0, 32'h00000141, 32'h0,        2'b00, 1'b0, 32'h00000000, 32'hDEADBEEF);
    add(1'b0, 32'h00000140, 32'h0,        2'b10, 1'b0, 32'h00000000, 32'hDEADBEEF);

    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b10, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].wr, vecs[k].addr, vecs[k].data, vecs[k].size, vecs[k].ext);
      if (vecs[k].wr) begin
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        #1;
      end else begin
        #1;
        check($sformatf("vec%0d out_val", k), bus.out_val, vecs[k].exp_out);
      end
      check($sformatf("vec%0d mem_map_io", k), bus.mem_map_io, vecs[k].exp_mmio);
    end

    // Read during a write sees the old contents until the edge.
    drive(1'b1, 32'd200, 32'hCAFEF00D, 2'b10, 1'b0);
    #1;
    check("rdw pre-edge", bus.out_val, 32'h00000000);
    @(posedge clk);
    #1;
    check("rdw post-edge", bus.out_val, 32'hCAFEF00D);
    bus.wr_en = 1'b0;

    // Reset beats a simultaneous write and clears all earlier data.
    rst = 1'b1;
    drive(1'b1, 32'd80, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wr_en = 1'b0;
    read_chk("rst+wr addr80", 32'd80, 2'b10, 1'b0, 32'h00000000);
    check("rst mem_map_io", bus.mem_map_io, 32'h00000000);
    read_chk("rst addr64", 32'd64, 2'b10, 1'b0, 32'h00000000);
    read_chk("rst addr100", 32'd100, 2'b10, 1'b0, 32'h00000000);
    read_chk("rst addr200", 32'd200, 2'b10, 1'b0, 32'h00000000);
    read_chk("rst addr252", 32'd252, 2'b10, 1'b0, 32'h00000000);
    read_chk("instr addr4", 32'd4, 2'b10, 1'b0, 32'h00000000);

    // The write that follows reset must land normally.
    drive(1'b1, 32'd80, 32'h12345678, 2'b10, 1'b0);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    read_chk("post-rst write", 32'd80, 2'b10, 1'b0, 32'h12345678);
    read_chk("post-rst byte83", 32'd83, 2'b00, 1'b1, 32'h00000012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
